lemming_walker: RTL and testbench

Parametrised multi-lemming controller for the Lemmings game logic: N independent walker state machines sharing one clock and reset. It extends the two-state left/right bump walker with falling, digging, and a fall-duration splat rule. It sits between the playfield collision logic, which supplies bump, ground and dig inputs per lemming, and the sprite/animation logic, which consumes the per-lemming action outputs.

---
 rtl/lemming_walker.sv | 141 ++++++++++++++
 tb/tb_lemming_walker.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/lemming_walker.sv
// N independent lemming walkers (walk / fall / dig / splat), sharing only clk and areset_n.
// Each channel is a Moore FSM with a saturating fall-duration counter.

module lemming_walker_ch #(
    parameter int SPLAT_CYCLES = 20,
    parameter int CW           = $clog2(SPLAT_CYCLES + 2)
) (
    input  logic clk,
    input  logic areset_n,
    input  logic bump_left_i,
    input  logic bump_right_i,
    input  logic ground_i,
    input  logic dig_i,
    output logic walk_left_o,
    output logic walk_right_o,
    output logic aaah_o,
    output logic digging_o,
    output logic splatted_o
);

    // state  | meaning
    // WALK_L | walking left
    // WALK_R | walking right
    // FALL_L | falling, resumes walking left on a survivable landing
    // FALL_R | falling, resumes walking right on a survivable landing
    // DIG_L  | digging, was facing left
    // DIG_R  | digging, was facing right
    // SPLAT  | dead, absorbing until reset

    typedef enum logic [2:0] {
        WALK_L = 3'd0,
        WALK_R = 3'd1,
        FALL_L = 3'd2,
        FALL_R = 3'd3,
        DIG_L  = 3'd4,
        DIG_R  = 3'd5,
        SPLAT  = 3'd6
    } state_t;

    // Counter holds F-1 during the F-th fall cycle; saturating one past the
    // limit keeps arbitrarily long falls fatal without wrapping.
    localparam logic [CW-1:0] SPLAT_LIM = CW'(SPLAT_CYCLES);
    localparam logic [CW-1:0] CNT_SAT   = CW'(SPLAT_CYCLES + 1);

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            state_q <= WALK_L;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        case (state_q)
            WALK_L: begin
                if (!ground_i)        state_d = FALL_L;
                else if (dig_i)       state_d = DIG_L;
                else if (bump_left_i) state_d = WALK_R;
            end
            WALK_R: begin
                if (!ground_i)         state_d = FALL_R;
                else if (dig_i)        state_d = DIG_R;
                else if (bump_right_i) state_d = WALK_L;
            end
            FALL_L, FALL_R: begin
                if (!ground_i) begin
                    cnt_d = (cnt_q >= CNT_SAT) ? CNT_SAT : cnt_q + CW'(1);
                end else if (cnt_q >= SPLAT_LIM) begin
                    state_d = SPLAT;
                end else begin
                    state_d = (state_q == FALL_L) ? WALK_L : WALK_R;
                end
            end
            DIG_L: begin
                if (!ground_i) state_d = FALL_L;
            end
            DIG_R: begin
                if (!ground_i) state_d = FALL_R;
            end
            SPLAT: begin
                state_d = SPLAT;
            end
            default: begin
                state_d = WALK_L;
            end
        endcase
    end

    assign walk_left_o  = (state_q == WALK_L);
    assign walk_right_o = (state_q == WALK_R);
    assign aaah_o       = (state_q == FALL_L) || (state_q == FALL_R);
    assign digging_o    = (state_q == DIG_L)  || (state_q == DIG_R);
    assign splatted_o   = (state_q == SPLAT);

endmodule

module lemming_walker #(
    parameter int N            = 1,
    parameter int SPLAT_CYCLES = 20,
    parameter int CW           = $clog2(SPLAT_CYCLES + 2)
) (
    input  logic         clk,
    input  logic         areset_n,
    input  logic [N-1:0] bump_left,
    input  logic [N-1:0] bump_right,
    input  logic [N-1:0] ground,
    input  logic [N-1:0] dig,
    output logic [N-1:0] walk_left,
    output logic [N-1:0] walk_right,
    output logic [N-1:0] aaah,
    output logic [N-1:0] digging,
    output logic [N-1:0] splatted
);

    for (genvar g = 0; g < N; g++) begin : g_ch
        lemming_walker_ch #(
            .SPLAT_CYCLES (SPLAT_CYCLES),
            .CW           (CW)
        ) u_ch (
            .clk          (clk),
            .areset_n     (areset_n),
            .bump_left_i  (bump_left[g]),
            .bump_right_i (bump_right[g]),
            .ground_i     (ground[g]),
            .dig_i        (dig[g]),
            .walk_left_o  (walk_left[g]),
            .walk_right_o (walk_right[g]),
            .aaah_o       (aaah[g]),
            .digging_o    (digging[g]),
            .splatted_o   (splatted[g])
        );
    end

endmodule

// File: tb/tb_lemming_walker.sv
// Bench for lemming_walker: one N=1/SPLAT_CYCLES=20 instance (lane 0) and one
// N=4/SPLAT_CYCLES=3 instance (lanes 1..4), checked every cycle against a lemming-level model.

module tb_lemming_walker;

    logic       clk;
    logic       areset_n;
    logic [4:0] bl, br, gnd, dg;

    logic [0:0] u1_wl, u1_wr, u1_aa, u1_dig, u1_spl;
    logic [3:0] u4_wl, u4_wr, u4_aa, u4_dig, u4_spl;

    int checks = 0;
    int errors = 0;

    lemming_walker #(.N(1), .SPLAT_CYCLES(20)) u1 (
        .clk        (clk),
        .areset_n   (areset_n),
        .bump_left  (bl[0:0]),
        .bump_right (br[0:0]),
        .ground     (gnd[0:0]),
        .dig        (dg[0:0]),
        .walk_left  (u1_wl),
        .walk_right (u1_wr),
        .aaah       (u1_aa),
        .digging    (u1_dig),
        .splatted   (u1_spl)
    );

    lemming_walker #(.N(4), .SPLAT_CYCLES(3)) u4 (
        .clk        (clk),
        .areset_n   (areset_n),
        .bump_left  (bl[4:1]),
        .bump_right (br[4:1]),
        .ground     (gnd[4:1]),
        .dig        (dg[4:1]),
        .walk_left  (u4_wl),
        .walk_right (u4_wr),
        .aaah       (u4_aa),
        .digging    (u4_dig),
        .splatted   (u4_spl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Lemming-level model: facing direction, activity flags, fall length in cycles.
    bit m_right [5];
    bit m_fall  [5];
    bit m_dig   [5];
    bit m_dead  [5];
    int m_flen  [5];

    function automatic int limit(input int lane);
        return (lane == 0) ? 20 : 3;
    endfunction

    always @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            for (int i = 0; i < 5; i++) begin
                m_right[i] = 0; m_fall[i] = 0; m_dig[i] = 0; m_dead[i] = 0; m_flen[i] = 0;
            end
        end else begin
            for (int i = 0; i < 5; i++) begin
                if (m_dead[i]) begin
                end else if (m_fall[i]) begin
                    if (!gnd[i]) m_flen[i]++;
                    else begin
                        m_fall[i] = 0;
                        if (m_flen[i] > limit(i)) m_dead[i] = 1;
                    end
                end else if (m_dig[i]) begin
                    if (!gnd[i]) begin m_dig[i] = 0; m_fall[i] = 1; m_flen[i] = 1; end
                end else begin
                    if (!gnd[i]) begin m_fall[i] = 1; m_flen[i] = 1; end
                    else if (dg[i]) m_dig[i] = 1;
                    else if (m_right[i] ? br[i] : bl[i]) m_right[i] = !m_right[i];
                end
            end
        end
    end

    int run0 = 0;
    int last_run0 = 0;

    always @(negedge clk) begin
        logic [4:0] ewl, ewr, eaa, edg, esp;
        for (int i = 0; i < 5; i++) begin
            esp[i] = m_dead[i];
            eaa[i] = !m_dead[i] && m_fall[i];
            edg[i] = !m_dead[i] && !m_fall[i] && m_dig[i];
            ewl[i] = !m_dead[i] && !m_fall[i] && !m_dig[i] && !m_right[i];
            ewr[i] = !m_dead[i] && !m_fall[i] && !m_dig[i] &&  m_right[i];
        end
        chk("cyc_walk_left",  32'({u4_wl,  u1_wl}),  32'(ewl));
        chk("cyc_walk_right", 32'({u4_wr,  u1_wr}),  32'(ewr));
        chk("cyc_aaah",       32'({u4_aa,  u1_aa}),  32'(eaa));
        chk("cyc_digging",    32'({u4_dig, u1_dig}), 32'(edg));
        chk("cyc_splatted",   32'({u4_spl, u1_spl}), 32'(esp));
        if (u1_aa[0]) run0++;
        else if (run0 > 0) begin last_run0 = run0; run0 = 0; end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        areset_n = 1'b0;
        bl = '0; br = '0; dg = '0; gnd = 5'h1f;
        #1;
        chk("rst_async_wl1", 32'(u1_wl), 32'h1);
        chk("rst_async_wl4", 32'(u4_wl), 32'hf);
        step(2);
        chk("rst_aaah4", 32'(u4_aa), 32'h0);
        areset_n = 1'b1;
        step(1);
        chk("idle_wl", 32'(u1_wl), 32'h1);

        // bump turn / opposite-side ignore
        bl[0] = 1; step(1);
        chk("bump_l_turn", 32'(u1_wr), 32'h1);
        step(1);
        chk("bump_l_held_right", 32'(u1_wr), 32'h1);
        bl[0] = 0; br[0] = 1; step(1);
        chk("bump_r_turn", 32'(u1_wl), 32'h1);
        br[0] = 0; bl[0] = 1; br[0] = 1; step(1);
        chk("both_bumps_turn", 32'(u1_wr), 32'h1);
        bl[0] = 0; br[0] = 0;

        // 20-cycle fall survives
        gnd[0] = 0; step(20);
        gnd[0] = 1; step(1);
        chk("fall20_walk_right", 32'(u1_wr), 32'h1);
        chk("fall20_alive", 32'(u1_spl), 32'h0);
        step(1);
        chk("fall20_len", 32'(last_run0), 32'd20);

        // 21-cycle fall splats, splat is sticky
        gnd[0] = 0; step(21);
        gnd[0] = 1; step(1);
        chk("fall21_splat", 32'(u1_spl), 32'h1);
        step(1);
        chk("fall21_len", 32'(last_run0), 32'd21);
        bl[0] = 1; step(1); bl[0] = 0; br[0] = 1; step(1); br[0] = 0;
        dg[0] = 1; step(1); dg[0] = 0; gnd[0] = 0; step(2); gnd[0] = 1; step(1);
        chk("splat_sticky", 32'(u1_spl), 32'h1);
        #3 areset_n = 1'b0;
        #1;
        chk("rst_mid_wl", 32'(u1_wl), 32'h1);
        chk("rst_mid_spl", 32'(u1_spl), 32'h0);
        step(1);
        areset_n = 1'b1;
        step(1);

        // dig
        dg[0] = 1; step(1);
        chk("dig_start", 32'(u1_dig), 32'h1);
        dg[0] = 0; br[0] = 1; step(1); br[0] = 0; bl[0] = 1; step(1); bl[0] = 0;
        chk("dig_ignores_bumps", 32'(u1_dig), 32'h1);
        gnd[0] = 0; step(1);
        chk("dig_to_fall", 32'(u1_aa), 32'h1);
        step(2);
        gnd[0] = 1; step(1);
        chk("dig_land_left", 32'(u1_wl), 32'h1);

        // priority: fall beats dig and bump
        gnd[0] = 0; dg[0] = 1; bl[0] = 1; step(1);
        chk("prio_fall", 32'(u1_aa), 32'h1);
        dg[0] = 0; bl[0] = 0; gnd[0] = 1; step(1);
        chk("prio_land_left", 32'(u1_wl), 32'h1);

        // dig held through landing acts one cycle later
        gnd[0] = 0; step(1);
        gnd[0] = 1; dg[0] = 1; step(1);
        chk("land_dig_walk", 32'(u1_wl), 32'h1);
        step(1);
        chk("land_dig_next", 32'(u1_dig), 32'h1);
        dg[0] = 0; gnd[0] = 0; step(1); gnd[0] = 1; step(1);

        // multichannel, SPLAT_CYCLES=3 (ch k = lane k+1)
        areset_n = 1'b0; step(1); areset_n = 1'b1; step(1);
        gnd[1] = 0; bl[2] = 1; bl[4] = 1; dg[3] = 1; step(1);
        bl[2] = 0; bl[4] = 0; dg[3] = 0;
        chk("mc_ch0_fall", 32'(u4_aa), 32'h1);
        chk("mc_turned", 32'(u4_wr), 32'ha);
        chk("mc_ch2_dig", 32'(u4_dig), 32'h4);
        step(3);
        gnd[1] = 1; step(1);
        chk("mc_ch0_splat4", 32'(u4_spl), 32'h1);
        gnd[2] = 0; step(3); gnd[2] = 1; step(1);
        chk("mc_ch1_fall3_ok", 32'(u4_wr), 32'ha);
        gnd[4] = 0; step(40); gnd[4] = 1; step(1);
        chk("mc_ch3_sat_splat", 32'(u4_spl), 32'h9);
        chk("mc_lane0_idle", 32'(u1_wl), 32'h1);
        step(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
